// File: rtl/nn_layer_sequencer.sv
// Sequences a chain of neural-net layer stages: latches the inputs, starts each stage in turn,
// waits for its done with a per-stage watchdog, and captures the final-stage result.
module nn_layer_sequencer #(
  parameter int NUM_STAGES       = 3,
  parameter int TIMEOUT_CYCLES   = 1023,
  parameter int BIT_WIDTH        = 9,
  parameter int num_input_units  = 2,
  parameter int num_output_units = 1
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         start,
  input  logic                                         abort,
  input  logic [num_input_units-1:0][BIT_WIDTH-1:0]    inputs,
  output logic [num_input_units-1:0][BIT_WIDTH-1:0]    layer_inputs,
  output logic [NUM_STAGES-1:0]                        stage_start,
  input  logic [NUM_STAGES-1:0]                        stage_done,
  input  logic [num_output_units-1:0][BIT_WIDTH-1:0]   stage_outputs,
  output logic [num_output_units-1:0][BIT_WIDTH-1:0]   outputs,
  output logic                                         busy,
  output logic                                         done,
  output logic                                         error
);

  localparam int KW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, FINISH} state_t;

  state_t        state, next_state;
  logic [KW-1:0] k, next_k;
  logic [TW-1:0] timer, next_timer;
  logic          err_set;
  logic          do_latch;

  always_comb begin
    next_state = state;
    next_k     = k;
    next_timer = timer;
    err_set    = 1'b0;
    do_latch   = 1'b0;
    case (state)
      IDLE: begin
        if (start && !abort) begin
          do_latch   = 1'b1;
          next_k     = '0;
          next_state = LAUNCH;
        end
      end
      LAUNCH: begin
        next_timer = '0;
        next_state = WAIT;
      end
      WAIT: begin
        // A done arriving on the last allowed cycle beats the watchdog.
        if (stage_done[k]) begin
          if (k == KW'(NUM_STAGES - 1)) begin
            next_state = FINISH;
          end else begin
            next_k     = k + 1'b1;
            next_state = LAUNCH;
          end
        end else if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
          err_set    = 1'b1;
          next_state = IDLE;
        end else begin
          next_timer = timer + 1'b1;
        end
      end
      FINISH: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
    if (abort && state != IDLE) begin
      next_state = IDLE;
      err_set    = 1'b0;
    end
  end

  // Outputs are registered from the next-state decision, so a pulse or result appears in the cycle
  // the FSM enters the matching state; an abort that redirects to IDLE also suppresses them.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      k            <= '0;
      timer        <= '0;
      stage_start  <= '0;
      done         <= 1'b0;
      busy         <= 1'b0;
      error        <= 1'b0;
      outputs      <= '0;
      layer_inputs <= '0;
    end else begin
      state       <= next_state;
      k           <= next_k;
      timer       <= next_timer;
      stage_start <= (next_state == LAUNCH) ? (NUM_STAGES'(1) << next_k) : '0;
      done        <= (next_state == FINISH);
      busy        <= (next_state != IDLE);
      if (do_latch) begin
        layer_inputs <= inputs;
        error        <= 1'b0;
      end else if (err_set) begin
        error <= 1'b1;
      end
      if (next_state == FINISH) begin
        outputs <= stage_outputs;
      end
    end
  end

endmodule
